// File: rtl/tree_refill_scheduler.sv
// tree_refill_scheduler: refill controller for the merge-sorter tree.
// Grants empty ways round-robin, fetches one block per grant from the record
// source and forwards it to the tree. Once a way's run is spent, the way gets a
// single all-ones terminator block. DONE rises once every way is terminated.

// Per-way bookkeeping: run position, terminator flag and post-delivery hold-off.
module tree_refill_way #(
  parameter int BLK_LOG = 4
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic             inc_i,
  input  logic             dlv_i,
  input  logic             term_i,
  output logic [BLK_LOG:0] blk_cnt_o,
  output logic             term_o,
  output logic             hold_zero_o
);
  localparam logic [BLK_LOG:0] RUN = {1'b1, {BLK_LOG{1'b0}}};

  logic [BLK_LOG:0] blk_cnt_q;
  logic             term_q;
  logic [1:0]       hold_q;

  // Counter saturates at the run length; hold-off reloads on every delivery
  // so the tree's lagging empty flag cannot trigger a duplicate grant.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      blk_cnt_q <= '0;
      term_q    <= 1'b0;
      hold_q    <= 2'd0;
    end else begin
      if (inc_i && blk_cnt_q != RUN) blk_cnt_q <= blk_cnt_q + (BLK_LOG+1)'(1);
      if (term_i) term_q <= 1'b1;
      if (dlv_i)                 hold_q <= 2'd3;
      else if (hold_q != 2'd0)   hold_q <= hold_q - 2'd1;
    end
  end

  assign blk_cnt_o   = blk_cnt_q;
  assign term_o      = term_q;
  assign hold_zero_o = (hold_q == 2'd0);
endmodule

module tree_refill_scheduler #(
  parameter int W_LOG   = 7,
  parameter int P_LOG   = 3,
  parameter int DATW    = 64,
  parameter int BLK_LOG = 4
) (
  input  logic                     CLK,
  input  logic                     RST_X,
  input  logic [(1<<W_LOG)-1:0]    TREE_EMP,
  output logic                     SRC_REQ,
  output logic [W_LOG-1:0]         SRC_REQ_IDX,
  output logic [BLK_LOG-1:0]       SRC_REQ_BLK,
  input  logic                     SRC_ACK,
  input  logic [(DATW<<P_LOG)-1:0] SRC_DIN,
  input  logic                     SRC_DINEN,
  output logic [(DATW<<P_LOG)-1:0] DOT,
  output logic                     DOTEN,
  output logic [W_LOG-1:0]         DOT_IDX,
  output logic                     DONE
);
  localparam int NW = 1 << W_LOG;
  localparam int BW = DATW << P_LOG;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_TERM} state_e;

  state_e                    state_q, state_d;
  logic [W_LOG-1:0]          last_q, last_d;
  logic [W_LOG-1:0]          way_q, way_d;
  logic                      req_q, req_d;
  logic [W_LOG-1:0]          req_idx_q, req_idx_d;
  logic [BLK_LOG-1:0]        req_blk_q, req_blk_d;
  logic [BW-1:0]             dot_q, dot_d;
  logic                      doten_q, doten_d;
  logic [W_LOG-1:0]          dot_idx_q, dot_idx_d;
  logic                      done_q, done_d;

  logic [NW-1:0]             inc, dlv, tset;
  logic [NW-1:0]             term_v, hold_zero, elig;
  logic [NW-1:0][BLK_LOG:0]  blk_cnt;
  logic                      win_vld;
  logic [W_LOG-1:0]          win, arb_idx;

  for (genvar g = 0; g < NW; g++) begin : g_way
    tree_refill_way #(.BLK_LOG(BLK_LOG)) u_way (
      .CLK         (CLK),
      .RST_X       (RST_X),
      .inc_i       (inc[g]),
      .dlv_i       (dlv[g]),
      .term_i      (tset[g]),
      .blk_cnt_o   (blk_cnt[g]),
      .term_o      (term_v[g]),
      .hold_zero_o (hold_zero[g])
    );
  end

  assign elig = TREE_EMP & ~term_v & hold_zero;

  // Rotated-priority search: first eligible way after the last grant wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    arb_idx = '0;
    for (int k = 0; k < NW; k++) begin
      arb_idx = last_q + W_LOG'(k + 1);
      if (!win_vld && elig[arb_idx]) begin
        win_vld = 1'b1;
        win     = arb_idx;
      end
    end
  end

  // Next-state and registered-output values; one transfer in flight at a time.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    way_d     = way_q;
    req_d     = req_q;
    req_idx_d = req_idx_q;
    req_blk_d = req_blk_q;
    dot_d     = dot_q;
    doten_d   = 1'b0;
    dot_idx_d = dot_idx_q;
    done_d    = done_q | (&term_v);
    inc       = '0;
    dlv       = '0;
    tset      = '0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          last_d = win;
          way_d  = win;
          // MSB set means the run is spent (counter saturates there).
          if (blk_cnt[win][BLK_LOG]) begin
            state_d = S_TERM;
          end else begin
            state_d   = S_REQ;
            req_d     = 1'b1;
            req_idx_d = win;
            req_blk_d = blk_cnt[win][BLK_LOG-1:0];
          end
        end
      end
      S_REQ: begin
        if (SRC_ACK) begin
          req_d      = 1'b0;
          inc[way_q] = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (SRC_DINEN) begin
          dot_d      = SRC_DIN;
          doten_d    = 1'b1;
          dot_idx_d  = way_q;
          dlv[way_q] = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_TERM: begin
        dot_d       = '1;
        doten_d     = 1'b1;
        dot_idx_d   = way_q;
        tset[way_q] = 1'b1;
        dlv[way_q]  = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; last grant starts at the top so way 0 goes first.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q   <= S_IDLE;
      last_q    <= '1;
      way_q     <= '0;
      req_q     <= 1'b0;
      req_idx_q <= '0;
      req_blk_q <= '0;
      dot_q     <= '0;
      doten_q   <= 1'b0;
      dot_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      way_q     <= way_d;
      req_q     <= req_d;
      req_idx_q <= req_idx_d;
      req_blk_q <= req_blk_d;
      dot_q     <= dot_d;
      doten_q   <= doten_d;
      dot_idx_q <= dot_idx_d;
      done_q    <= done_d;
    end
  end

  assign SRC_REQ     = req_q;
  assign SRC_REQ_IDX = req_idx_q;
  assign SRC_REQ_BLK = req_blk_q;
  assign DOT         = dot_q;
  assign DOTEN       = doten_q;
  assign DOT_IDX     = dot_idx_q;
  assign DONE        = done_q;
endmodule

// File: tb/tb_tree_refill_scheduler.sv
// Bench for tree_refill_scheduler: emulated tree and record source, a
// transaction-level reference model checked every cycle, plus scenario checks.
module tb_tree_refill_scheduler;
  localparam int W_LOG = 7, P_LOG = 3, DATW = 64, BLK_LOG = 4;
  localparam int NW  = 1 << W_LOG;
  localparam int BW  = DATW << P_LOG;
  localparam int RUN = 1 << BLK_LOG;
  localparam logic [BW-1:0] ONES = '1;

  logic               CLK = 1'b0;
  logic               RST_X = 1'b0;
  logic [NW-1:0]      TREE_EMP = '0;
  logic               SRC_REQ;
  logic [W_LOG-1:0]   SRC_REQ_IDX;
  logic [BLK_LOG-1:0] SRC_REQ_BLK;
  logic               SRC_ACK = 1'b0;
  logic [BW-1:0]      SRC_DIN = '0;
  logic               SRC_DINEN = 1'b0;
  logic [BW-1:0]      DOT;
  logic               DOTEN;
  logic [W_LOG-1:0]   DOT_IDX;
  logic               DONE;

  tree_refill_scheduler #(.W_LOG(W_LOG), .P_LOG(P_LOG), .DATW(DATW), .BLK_LOG(BLK_LOG)) dut (
    .CLK(CLK), .RST_X(RST_X), .TREE_EMP(TREE_EMP),
    .SRC_REQ(SRC_REQ), .SRC_REQ_IDX(SRC_REQ_IDX), .SRC_REQ_BLK(SRC_REQ_BLK),
    .SRC_ACK(SRC_ACK), .SRC_DIN(SRC_DIN), .SRC_DINEN(SRC_DINEN),
    .DOT(DOT), .DOTEN(DOTEN), .DOT_IDX(DOT_IDX), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_err = 0;

  task automatic check(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic check_w(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < BW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- reference model (transaction level) ----------------
  int  m_cyc, m_last, j_way;
  int  m_blk [NW];
  int  m_free[NW];
  bit  m_term[NW];
  bit  j_act, j_term, j_acked;
  bit  e_req, e_doten, e_done;
  int  e_idx, e_blk, e_didx;
  logic [BW-1:0] e_dot;

  task automatic model_reset();
    m_cyc = 0; m_last = NW - 1;
    for (int i = 0; i < NW; i++) begin m_blk[i] = 0; m_free[i] = 0; m_term[i] = 1'b0; end
    j_act = 1'b0; j_term = 1'b0; j_acked = 1'b0; j_way = 0;
    e_req = 1'b0; e_doten = 1'b0; e_done = 1'b0; e_idx = 0; e_blk = 0; e_didx = 0; e_dot = '0;
  endtask

  task automatic model_step();
    bit allt, found;
    int w;
    allt = 1'b1;
    for (int i = 0; i < NW; i++) if (!m_term[i]) allt = 1'b0;
    m_cyc++;
    e_doten = 1'b0;
    if (!j_act) begin
      found = 1'b0;
      for (int k = 1; k <= NW; k++) begin
        w = (m_last + k) % NW;
        if (!found && TREE_EMP[w] && !m_term[w] && m_cyc >= m_free[w]) begin
          found = 1'b1; j_act = 1'b1; j_way = w; m_last = w; j_acked = 1'b0;
          j_term = (m_blk[w] == RUN);
          if (!j_term) begin e_req = 1'b1; e_idx = w; e_blk = m_blk[w] % RUN; end
        end
      end
    end else if (j_term) begin
      e_doten = 1'b1; e_dot = ONES; e_didx = j_way;
      m_term[j_way] = 1'b1; m_free[j_way] = m_cyc + 4; j_act = 1'b0;
    end else if (!j_acked) begin
      if (SRC_ACK) begin j_acked = 1'b1; e_req = 1'b0; m_blk[j_way]++; end
    end else if (SRC_DINEN) begin
      e_doten = 1'b1; e_dot = SRC_DIN; e_didx = j_way;
      m_free[j_way] = m_cyc + 4; j_act = 1'b0;
    end
    e_done = e_done | allt;
  endtask

  always @(posedge CLK or negedge RST_X) begin
    if (!RST_X) model_reset();
    else        model_step();
  end

  // Cycle compare against the model, away from the active edge.
  always @(negedge CLK) begin
    if (RST_X) begin
      check("src_req", int'(SRC_REQ), int'(e_req));
      if (e_req) begin
        check("src_req_idx", int'(SRC_REQ_IDX), e_idx);
        check("src_req_blk", int'(SRC_REQ_BLK), e_blk);
      end
      check("doten", int'(DOTEN), int'(e_doten));
      if (e_doten) begin
        check("dot_idx", int'(DOT_IDX), e_didx);
        check_w("dot", DOT, e_dot);
      end
      check("done", int'(DONE), int'(e_done));
    end
  end

  // ---------------- tree / source emulation ----------------
  logic [NW-1:0] act, emp;
  int  lagc[NW], drc[NW];
  int  ack_pct, dly_min, dly_max, dmin, dmax, s_cd;
  bit  stall, spur, prev_req, t3_seen, done_seen;
  int  ncyc, n_term, n_data, t3, g3_after, last_term_cyc, done_cyc;
  int  gq_idx[$], gq_blk[$];

  task automatic emu_reset();
    s_cd = 0; SRC_ACK = 1'b0; SRC_DINEN = 1'b0; SRC_DIN = '0;
    emp = '1;
    for (int i = 0; i < NW; i++) begin lagc[i] = 0; drc[i] = 0; end
    TREE_EMP = emp & act;
    prev_req = 1'b0; t3_seen = 1'b0; done_seen = 1'b0;
    ncyc = 0; n_term = 0; n_data = 0; t3 = 0; g3_after = 0; last_term_cyc = 0; done_cyc = 0;
    gq_idx.delete(); gq_blk.delete();
  endtask

  task automatic drive_step();
    ncyc++;
    if (SRC_REQ && !prev_req) begin
      gq_idx.push_back(int'(SRC_REQ_IDX));
      gq_blk.push_back(int'(SRC_REQ_BLK));
      if (t3_seen && SRC_REQ_IDX == W_LOG'(3)) g3_after++;
    end
    prev_req = SRC_REQ;
    if (DOTEN) begin
      if (DOT == ONES) begin
        n_term++; last_term_cyc = ncyc;
        if (DOT_IDX == W_LOG'(3)) begin t3++; t3_seen = 1'b1; end
      end else n_data++;
    end
    if (DONE && !done_seen) begin done_seen = 1'b1; done_cyc = ncyc; end
    // record source: one outstanding fetch, data at least one cycle after ack
    SRC_ACK = 1'b0; SRC_DINEN = 1'b0;
    if (s_cd != 0) begin
      s_cd--;
      if (s_cd == 0) begin SRC_DINEN = 1'b1; SRC_DIN = rand_block(); end
    end else if (SRC_REQ && !stall) begin
      if ($urandom_range(99) < ack_pct) begin SRC_ACK = 1'b1; s_cd = $urandom_range(dly_max, dly_min); end
    end else if (spur && $urandom_range(15) == 0) begin
      SRC_DINEN = 1'b1; SRC_DIN = rand_block();
    end
    // tree: empty drops one cycle after the block lands, refills after a drain time
    for (int i = 0; i < NW; i++) begin
      if (lagc[i] != 0) begin
        lagc[i]--;
        if (lagc[i] == 0) begin emp[i] = 1'b0; drc[i] = $urandom_range(dmax, dmin); end
      end else if (!emp[i] && drc[i] != 0) begin
        drc[i]--;
        if (drc[i] == 0) emp[i] = 1'b1;
      end
    end
    if (DOTEN) lagc[DOT_IDX] = 1;
    TREE_EMP = emp & act;
  endtask

  task automatic tick();
    @(negedge CLK);
    drive_step();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_src_req"}, int'(SRC_REQ), 0);
    check({tag, "_src_req_idx"}, int'(SRC_REQ_IDX), 0);
    check({tag, "_src_req_blk"}, int'(SRC_REQ_BLK), 0);
    check_w({tag, "_dot"}, DOT, '0);
    check({tag, "_doten"}, int'(DOTEN), 0);
    check({tag, "_dot_idx"}, int'(DOT_IDX), 0);
    check({tag, "_done"}, int'(DONE), 0);
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST_X = 1'b0;
    emu_reset();
    #1;
    check_zero("rst");
    @(negedge CLK);
    @(negedge CLK);
    RST_X = 1'b1;
  endtask

  initial begin
    int n;
    act = '1; stall = 1'b0; spur = 1'b0;
    ack_pct = 100; dly_min = 2; dly_max = 2; dmin = 200; dmax = 200;

    // A: all ways empty, immediate ack, data 2 cycles later -> ways 0,1,2,3 at block 0
    apply_reset();
    repeat (40) tick();
    check("a_grants", int'(gq_idx.size() >= 4), 1);
    for (int k = 0; k < 4; k++) begin
      check("a_grant_idx", gq_idx[k], k);
      check("a_grant_blk", gq_blk[k], 0);
    end

    // B: ack withheld for 10 cycles -> request held stable, no delivery
    stall = 1'b1;
    apply_reset();
    n = 0;
    while (!SRC_REQ && n < 10) begin tick(); n++; end
    for (int k = 0; k < 10; k++) begin
      tick();
      check("b_req_held", int'(SRC_REQ), 1);
      check("b_idx_held", int'(SRC_REQ_IDX), 0);
      check("b_blk_held", int'(SRC_REQ_BLK), 0);
      check("b_no_doten", int'(DOTEN), 0);
    end
    stall = 1'b0;
    repeat (30) tick();

    // C: asynchronous reset while waiting for data
    dly_min = 6; dly_max = 6;
    apply_reset();
    n = 0;
    while (gq_idx.size() < 3 && n < 100) begin tick(); n++; end
    tick(); tick();
    check("c_in_wait_idx", int'(SRC_REQ_IDX), 2);
    @(posedge CLK); #2;
    RST_X = 1'b0;
    #1;
    check_zero("c_async");
    emu_reset();
    @(negedge CLK);
    RST_X = 1'b1;
    n = 0;
    while (gq_idx.size() < 1 && n < 20) begin tick(); n++; end
    check("c_first_idx", gq_idx[0], 0);
    check("c_first_blk", gq_blk[0], 0);

    // D: only ways 3 and 5 active, fast refill -> full runs, one terminator each
    act = '0; act[3] = 1'b1; act[5] = 1'b1;
    dly_min = 1; dly_max = 3; dmin = 1; dmax = 1; spur = 1'b1;
    apply_reset();
    n = 0;
    while (n_term < 2 && n < 3000) begin tick(); n++; end
    repeat (60) tick();
    begin
      int b5[$];
      foreach (gq_idx[k]) if (gq_idx[k] == 5) b5.push_back(gq_blk[k]);
      check("d_way5_reqs", b5.size(), RUN);
      for (int k = 0; k < RUN; k++) check("d_way5_blk", b5[k], k);
    end
    check("d_terms", n_term, 2);
    check("d_way3_term", t3, 1);
    check("d_way3_regrant", g3_after, 0);

    // E: all ways run to termination under random ack/latency/drain
    act = '1; ack_pct = 70; dmin = 1; dmax = 6;
    apply_reset();
    n = 0;
    while (!done_seen && n < 40000) begin tick(); n++; end
    check("e_done_rise", int'(DONE), 1);
    check("e_done_latency", done_cyc - last_term_cyc, 1);
    check("e_terms", n_term, NW);
    check("e_data_blocks", n_data, NW * RUN);
    repeat (20) tick();
    check("e_done_sticky", int'(DONE), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
